frame_packer64: RTL and testbench
=================================

# frame_packer64

Upstream companion of the 64-bit CRC16 checker. Accepts a byte stream captured from the monitored bus, assembles each 8-byte frame MSB-first into a 64-bit word, and holds that word stable on `dataOut` until the checker acknowledges it. Reports framing faults: restart mid-frame, stray bytes and, optionally, inter-byte gap timeout. Also keeps frame and drop statistics.

## Interface
Parameters:
- `GAP_MAX`, default 8'd255: idle cycles allowed between bytes inside a frame. Range 1..255; 0 is illegal. Used only with `GAP_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `byteIn`  in  8  byte from bus capture.
- `byteValid`  in  1  `byteIn` is valid this cycle.
- `byteSof`  in  1  qualifies `byteIn` as the first byte of a frame.
- `byteReady`  out  1  block can accept a byte this cycle.
- `dataOut`  out  64  assembled frame; first byte in [63:56], last byte in [7:0].
- `frameValid`  out  1  `dataOut` holds a complete frame.
- `frameAck`  in  1  downstream has consumed `dataOut`.
- `byteCount`  out  4  bytes collected in the current frame (0..8).
- `sofErr`  out  1  one-cycle pulse: SOF received mid-frame.
- `gapErr`  out  1  one-cycle pulse: gap timeout. Tied 0 without the macro.
- `frameCount`  out  16  completed frames; wraps 16'hFFFF -> 0.
- `dropCount`  out  8  bytes discarded in IDLE; saturates at 8'hFF.

## Operation
- A byte is accepted on a rising edge with `byteValid && byteReady`.
- States: IDLE, COLLECT, HOLD.
- IDLE
  - `byteReady`=1.
  - Accepted byte with `byteSof`=1: write to [63:56], zero [55:0], `byteCount`=1, go to COLLECT.
  - Accepted byte with `byteSof`=0: discard and increment `dropCount` (saturating).
- COLLECT
  - `byteReady`=1.
  - Accepted byte with `byteSof`=0: write to bits [63-8*byteCount -: 8] and increment `byteCount`.
  - When the 8th byte is written: go to HOLD, set `frameValid`, increment `frameCount`.
  - Accepted byte with `byteSof`=1: pulse `sofErr`, restart the frame with this byte as byte 1 (`byteCount`=1, [55:0] zeroed), stay in COLLECT.
- HOLD
  - `byteReady`=0 and `dataOut` frozen; input bytes are back-pressured, not dropped.
  - `frameAck`=1: clear `frameValid`, set `byteCount`=0, go to IDLE.
  - `frameAck` in IDLE or COLLECT is ignored.
- Reset (asynchronous, any state, including mid-frame):
  - State IDLE; `dataOut`=0, `frameValid`=0, `byteCount`=0, `sofErr`=0, `gapErr`=0, `frameCount`=0, `dropCount`=0, gap counter 0.
  - `byteReady`=1 (IDLE value) while reset is asserted.
  - A partial frame is lost.

## Timing
- `byteReady` is a combinational decode of state: 1 in IDLE/COLLECT, 0 in HOLD.
- `frameValid` rises on the same edge that accepts byte 8.
  - Minimum latency from the first-byte edge to `frameValid`=1 is 7 cycles (back-to-back bytes).
- `frameValid` falls on the edge that samples `frameAck`=1. The earliest next byte is accepted one edge later.
- `dataOut` changes only on byte acceptance. It is stable for the whole of HOLD, so the checker can sample it on the falling edge.
- `sofErr` and `gapErr` are high for exactly one cycle, registered on the causing edge.

## Configuration
- `GAP_TIMEOUT_EN` defined:
  - An 8-bit gap counter runs in COLLECT. It clears on every accepted byte and increments on each cycle without one.
  - When it reaches `GAP_MAX`: pulse `gapErr`, set `byteCount`=0, return to IDLE. `dataOut` keeps its partial content; `frameValid` stays 0.
  - If a byte is accepted on the same edge the counter reaches `GAP_MAX`, the byte wins and no timeout occurs.
- `GAP_TIMEOUT_EN` undefined: no gap counter; `gapErr` is constant 0; COLLECT waits indefinitely.

## Test plan
- Reset, then bytes 11,22,33,44,55,66,77,88 back-to-back (SOF on 11) -> `frameValid`=1 on 8th edge, `dataOut`=64'h1122334455667788, `frameCount`=1, `byteReady`=0.
- Hold `byteValid`=1 during HOLD for 10 cycles, then pulse `frameAck` -> no byte accepted in HOLD; `frameValid` drops; the pending byte is accepted on the next edge.
- Three bytes without SOF in IDLE -> `dropCount`=3, state stays IDLE. 300 more -> `dropCount`=8'hFF.
- SOF frame AA,BB,CC, then SOF DD followed by 7 bytes 01..07 -> `sofErr` one pulse at DD; `dataOut`=64'hDD01020304050607.
- `GAP_TIMEOUT_EN`, `GAP_MAX`=4: SOF byte, then idle 4 cycles -> `gapErr` pulse, `byteCount`=0, IDLE. Repeat with a byte on the 4th idle cycle -> no `gapErr`.
- Assert `rst` low after byte 5 -> all outputs reach reset values immediately; a following complete frame is assembled correctly.

Source files
------------

// File: rtl/frame_packer64_if.sv
// Byte-stream / frame handshake bundle for frame_packer64.
// slave: the packer (consumes bytes, produces frames); master: its environment.
interface frame_packer64_if;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteSof;
    logic        byteReady;
    logic [63:0] dataOut;
    logic        frameValid;
    logic        frameAck;

    modport master (
        output byteIn, byteValid, byteSof, frameAck,
        input  byteReady, dataOut, frameValid
    );

    modport slave (
        input  byteIn, byteValid, byteSof, frameAck,
        output byteReady, dataOut, frameValid
    );
endinterface

// File: rtl/frame_packer64.sv
// Packs an 8-byte SOF-delimited stream MSB-first into a held 64-bit frame.
// Ports: clk, rst (async active-low), bus (byte in / frame out handshake),
// byteCount, sofErr, gapErr, frameCount, dropCount.
// Optional feature macro: GAP_TIMEOUT_EN (inter-byte gap timeout, GAP_MAX).
module frame_packer64 #(
    parameter logic [7:0] GAP_MAX = 8'd255
) (
    input  logic              clk,
    input  logic              rst,
    frame_packer64_if.slave   bus,
    output logic [3:0]        byteCount,
    output logic              sofErr,
    output logic              gapErr,
    output logic [15:0]       frameCount,
    output logic [7:0]        dropCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sofErr_q, sofErr_d;
    logic        gapErr_q, gapErr_d;
    logic [15:0] frames_q, frames_d;
    logic [7:0]  drops_q, drops_d;
    logic [7:0]  gap_q, gap_d;
    logic        ready;
    logic        accept;

    assign ready  = (state_q != HOLD);
    assign accept = bus.byteValid && ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        sofErr_d = 1'b0;
        gapErr_d = 1'b0;
        frames_d = frames_q;
        drops_d  = drops_q;
        gap_d    = 8'd0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.byteSof) begin
                        data_d  = {bus.byteIn, 56'h0};
                        cnt_d   = 4'd1;
                        state_d = COLLECT;
                    end else if (drops_q != 8'hFF) begin
                        drops_d = drops_q + 8'd1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (bus.byteSof) begin
                        // Restart: the SOF byte becomes byte 1 of a new frame
                        sofErr_d = 1'b1;
                        data_d   = {bus.byteIn, 56'h0};
                        cnt_d    = 4'd1;
                    end else begin
                        for (int i = 1; i < 8; i++) begin
                            if (cnt_q == 4'(i))
                                data_d[63-8*i -: 8] = bus.byteIn;
                        end
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_d  = HOLD;
                            frames_d = frames_q + 16'd1;
                        end
                    end
                end
`ifdef GAP_TIMEOUT_EN
                else begin
                    // An accepted byte always beats the timeout
                    gap_d = gap_q + 8'd1;
                    if (gap_d == GAP_MAX) begin
                        gapErr_d = 1'b1;
                        cnt_d    = 4'd0;
                        gap_d    = 8'd0;
                        state_d  = IDLE;
                    end
                end
`endif
            end
            HOLD: begin
                if (bus.frameAck) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            data_q   <= 64'h0;
            cnt_q    <= 4'd0;
            sofErr_q <= 1'b0;
            gapErr_q <= 1'b0;
            frames_q <= 16'd0;
            drops_q  <= 8'd0;
            gap_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            sofErr_q <= sofErr_d;
            gapErr_q <= gapErr_d;
            frames_q <= frames_d;
            drops_q  <= drops_d;
            gap_q    <= gap_d;
        end
    end

`ifdef GAP_TIMEOUT_EN
    assign gapErr = gapErr_q;
`else
    logic unused_gap;
    assign unused_gap = ^{GAP_MAX, gapErr_q, gap_q};
    assign gapErr     = 1'b0;
`endif

    assign bus.byteReady  = ready;
    assign bus.dataOut    = data_q;
    assign bus.frameValid = (state_q == HOLD);
    assign byteCount      = cnt_q;
    assign sofErr         = sofErr_q;
    assign frameCount     = frames_q;
    assign dropCount      = drops_q;

endmodule

// File: tb/tb_frame_packer64.sv
// Directed self-checking bench for frame_packer64.
// Inputs driven 1 time unit after each rising edge; outputs sampled there too.
module tb_frame_packer64;

    logic        clk;
    logic        rst;
    logic [3:0]  byteCount;
    logic        sofErr;
    logic        gapErr;
    logic [15:0] frameCount;
    logic [7:0]  dropCount;
    int          n_cmp;
    int          n_bad;

    frame_packer64_if bus ();

    frame_packer64 #(.GAP_MAX(8'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .byteCount  (byteCount),
        .sofErr     (sofErr),
        .gapErr     (gapErr),
        .frameCount (frameCount),
        .dropCount  (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic sof);
        bus.byteIn    = b;
        bus.byteSof   = sof;
        bus.byteValid = 1'b1;
        tick();
        bus.byteValid = 1'b0;
        bus.byteSof   = 1'b0;
    endtask

    task automatic ack();
        bus.frameAck = 1'b1;
        tick();
        bus.frameAck = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.byteIn    = 8'h00;
        bus.byteValid = 1'b0;
        bus.byteSof   = 1'b0;
        bus.frameAck  = 1'b0;
        rst = 1'b0;
        #23;
        chk("rst_ready", bus.byteReady, 1);
        chk("rst_data", bus.dataOut, 64'h0);
        chk("rst_fv", bus.frameValid, 0);
        chk("rst_cnt", byteCount, 0);
        chk("rst_sof", sofErr, 0);
        chk("rst_gap", gapErr, 0);
        chk("rst_frames", frameCount, 0);
        chk("rst_drops", dropCount, 0);
        rst = 1'b1;
        tick();

        // Frame 1, back-to-back
        send(8'h11, 1'b1);
        chk("f1_cnt1", byteCount, 1);
        chk("f1_data1", bus.dataOut, 64'h1100000000000000);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        chk("f1_cnt7", byteCount, 7);
        chk("f1_fv7", bus.frameValid, 0);
        send(8'h88, 1'b0);
        chk("f1_fv", bus.frameValid, 1);
        chk("f1_data", bus.dataOut, 64'h1122334455667788);
        chk("f1_frames", frameCount, 1);
        chk("f1_ready", bus.byteReady, 0);
        chk("f1_cnt8", byteCount, 8);

        // Back-pressure in HOLD with a pending SOF byte
        bus.byteIn    = 8'h99;
        bus.byteSof   = 1'b1;
        bus.byteValid = 1'b1;
        repeat (10) tick();
        chk("bp_fv", bus.frameValid, 1);
        chk("bp_data", bus.dataOut, 64'h1122334455667788);
        chk("bp_cnt", byteCount, 8);
        chk("bp_drops", dropCount, 0);
        bus.frameAck = 1'b1;
        tick();
        bus.frameAck = 1'b0;
        chk("ack_fv", bus.frameValid, 0);
        chk("ack_cnt", byteCount, 0);
        chk("ack_ready", bus.byteReady, 1);
        chk("ack_data", bus.dataOut, 64'h1122334455667788);
        tick();
        bus.byteValid = 1'b0;
        bus.byteSof   = 1'b0;
        chk("pend_cnt", byteCount, 1);
        chk("pend_data", bus.dataOut, 64'h9900000000000000);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        send(8'hA5, 1'b0);
        send(8'hA6, 1'b0);
        send(8'hA7, 1'b0);
        chk("f2_data", bus.dataOut, 64'h99A1A2A3A4A5A6A7);
        chk("f2_frames", frameCount, 2);
        ack();

        // Stray bytes in IDLE
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        chk("drop3", dropCount, 3);
        chk("drop_cnt", byteCount, 0);
        chk("drop_ready", bus.byteReady, 1);
        chk("drop_data", bus.dataOut, 64'h99A1A2A3A4A5A6A7);
        for (int i = 0; i < 300; i++) send(8'(i), 1'b0);
        chk("drop_sat", dropCount, 8'hFF);

        // Restart mid-frame
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        chk("rs_pre", sofErr, 0);
        send(8'hDD, 1'b1);
        chk("rs_pulse", sofErr, 1);
        chk("rs_cnt", byteCount, 1);
        send(8'h01, 1'b0);
        chk("rs_low", sofErr, 0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        chk("rs_fv", bus.frameValid, 1);
        chk("rs_data", bus.dataOut, 64'hDD01020304050607);
        chk("rs_frames", frameCount, 3);
        ack();

`ifdef GAP_TIMEOUT_EN
        send(8'h5A, 1'b1);
        repeat (3) tick();
        chk("gap_early", gapErr, 0);
        chk("gap_cnt1", byteCount, 1);
        tick();
        chk("gap_pulse", gapErr, 1);
        chk("gap_cnt0", byteCount, 0);
        chk("gap_fv", bus.frameValid, 0);
        chk("gap_data", bus.dataOut, 64'h5A00000000000000);
        tick();
        chk("gap_low", gapErr, 0);
        send(8'h77, 1'b0);
        chk("gap_idle", byteCount, 0);
        send(8'h5B, 1'b1);
        repeat (3) tick();
        send(8'h01, 1'b0);
        chk("gap_win", gapErr, 0);
        chk("gap_win_cnt", byteCount, 2);
        tick();
        chk("gap_win2", gapErr, 0);
`else
        send(8'h5A, 1'b1);
        repeat (20) tick();
        chk("nogap_err", gapErr, 0);
        chk("nogap_cnt", byteCount, 1);
`endif

        // Async reset after byte 5
        send(8'hF1, 1'b1);
        send(8'hF2, 1'b0);
        send(8'hF3, 1'b0);
        send(8'hF4, 1'b0);
        send(8'hF5, 1'b0);
        chk("ar_cnt5", byteCount, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_data", bus.dataOut, 64'h0);
        chk("ar_cnt", byteCount, 0);
        chk("ar_frames", frameCount, 0);
        chk("ar_drops", dropCount, 0);
        chk("ar_ready", bus.byteReady, 1);
        chk("ar_fv", bus.frameValid, 0);
        chk("ar_sof", sofErr, 0);
        #3;
        rst = 1'b1;
        tick();
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        chk("ar_f_fv", bus.frameValid, 1);
        chk("ar_f_data", bus.dataOut, 64'h0102030405060708);
        chk("ar_f_frames", frameCount, 1);
        ack();
        chk("ar_f_ack", bus.frameValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
